// File: rtl/sap_controller_if.sv
// Handshake-free control bundle between the SAP sequencer and its environment:
// run/opcode in, control word, ring state and halt flag out.
interface sap_controller_if #(
    parameter int OPCODE_W = 4
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic [11:0]         control_word;
    logic [5:0]          t_state;
    logic                halted;

    modport master (
        output run,
        output opcode,
        input  control_word,
        input  t_state,
        input  halted
    );

    modport slave (
        input  run,
        input  opcode,
        output control_word,
        output t_state,
        output halted
    );
endinterface

// File: rtl/sap_controller.sv
// SAP controller-sequencer: six-state one-hot ring (T1..T6) with fetch/execute
// decode for LDA/ADD/SUB/OUT/HLT, producing a registered 12-bit control word.
module sap_controller #(
    parameter int                     OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0]    OP_LDA   = 4'b0000,
    parameter logic [OPCODE_W-1:0]    OP_ADD   = 4'b0001,
    parameter logic [OPCODE_W-1:0]    OP_SUB   = 4'b0010,
    parameter logic [OPCODE_W-1:0]    OP_OUT   = 4'b1110,
    parameter logic [OPCODE_W-1:0]    OP_HLT   = 4'b1111
) (
    input logic              clock,
    input logic              reset,
    sap_controller_if.slave  bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [11:0] CW_CP = 12'h800;
    localparam logic [11:0] CW_EP = 12'h400;
    localparam logic [11:0] CW_LM = 12'h200;
    localparam logic [11:0] CW_CE = 12'h100;
    localparam logic [11:0] CW_LI = 12'h080;
    localparam logic [11:0] CW_EI = 12'h040;
    localparam logic [11:0] CW_LA = 12'h020;
    localparam logic [11:0] CW_EA = 12'h010;
    localparam logic [11:0] CW_SU = 12'h008;
    localparam logic [11:0] CW_EU = 12'h004;
    localparam logic [11:0] CW_LB = 12'h002;
    localparam logic [11:0] CW_LO = 12'h001;
    localparam logic [11:0] CW_BUS_DRIVERS = CW_EP | CW_CE | CW_EI | CW_EA | CW_EU;

    t_state_e            r_state;
    logic [11:0]         r_cw;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_halted;
    // Low after reset or a freeze: the next run edge re-presents the held state instead of stepping.
    logic                r_active;

    t_state_e            w_next_state;
    logic [OPCODE_W-1:0] w_dec_op;

    function automatic logic [11:0] decode(input t_state_e t, input logic [OPCODE_W-1:0] op);
        logic [11:0] cw;
        cw = '0;
        case (t)
            T1: cw = CW_EP | CW_LM;
            T2: cw = CW_CP;
            T3: cw = CW_CE | CW_LI;
            T4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) cw = CW_EI | CW_LM;
                else if (op == OP_OUT)                            cw = CW_EA | CW_LO;
            end
            T5: begin
                if (op == OP_LDA)                       cw = CW_CE | CW_LA;
                else if (op == OP_ADD || op == OP_SUB)  cw = CW_CE | CW_LB;
            end
            T6: begin
                if (op == OP_ADD)       cw = CW_EU | CW_LA;
                else if (op == OP_SUB)  cw = CW_EU | CW_SU | CW_LA;
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

    always_comb begin
        w_next_state = T1;
        case (r_state)
            T1:      w_next_state = T2;
            T2:      w_next_state = T3;
            T3:      w_next_state = T4;
            T4:      w_next_state = T5;
            T5:      w_next_state = T6;
            default: w_next_state = T1;
        endcase
    end

    // The T4 word is decoded from the opcode being captured on this same edge.
    assign w_dec_op = (r_state == T3) ? bus.opcode : r_opcode;

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= T1;
            r_cw     <= '0;
            r_opcode <= '0;
            r_halted <= 1'b0;
            r_active <= 1'b0;
        end else if (!r_halted) begin
            if (!bus.run) begin
                r_cw     <= '0;
                r_active <= 1'b0;
            end else if (!r_active) begin
                r_cw     <= decode(r_state, r_opcode);
                r_active <= 1'b1;
            end else if (r_state == T3 && bus.opcode == OP_HLT) begin
                r_state  <= T4;
                r_opcode <= bus.opcode;
                r_cw     <= '0;
                r_halted <= 1'b1;
            end else begin
                r_state <= w_next_state;
                r_cw    <= decode(w_next_state, w_dec_op);
                if (r_state == T3) r_opcode <= bus.opcode;
            end
        end
    end

    assign bus.control_word = r_cw;
    assign bus.t_state      = r_state;
    assign bus.halted       = r_halted;

    a_bus_exclusive: assert property (@(posedge clock) $onehot0(r_cw & CW_BUS_DRIVERS));

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: directed vectors push expected words,
// a monitor pops and compares after each rising edge.
module tb_sap_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sap_controller_if bus_if ();

    sap_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [11:0] cw;
        logic [5:0]  t;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    localparam logic [11:0] BUS_MASK = 12'h554; // ep, ce, ei, ea, eu

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; the expectation is for the next rising edge.
    task automatic step(input string name, input logic rst, input logic run, input logic [3:0] op,
                        input logic [11:0] cw, input logic [5:0] t, input logic h);
        exp_t e;
        @(negedge clock);
        #1;
        reset         = rst;
        bus_if.run    = run;
        bus_if.opcode = op;
        e.name = name; e.cw = cw; e.t = t; e.h = h;
        sb.push_back(e);
    endtask

    task automatic fetch(input string name, input logic [3:0] op);
        step({name, "_t1"}, 1'b0, 1'b1, op, 12'h600, 6'h01, 1'b0);
        step({name, "_t2"}, 1'b0, 1'b1, op, 12'h800, 6'h02, 1'b0);
        step({name, "_t3"}, 1'b0, 1'b1, op, 12'h180, 6'h04, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, ".cw"}, bus_if.control_word, e.cw);
                check({e.name, ".t"}, 12'(bus_if.t_state), 12'(e.t));
                check({e.name, ".halted"}, 12'(bus_if.halted), 12'(e.h));
                mon_en = 1'b1;
            end
            if (mon_en)
                check("bus_excl", 12'($onehot0(bus_if.control_word & BUS_MASK)), 12'h001);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] ops [5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE; ops[4] = 4'h5;
        bus_if.run    = 1'b0;
        bus_if.opcode = 4'h0;

        // Reset with run low still resets.
        step("reset", 1'b1, 1'b0, 4'h0, 12'h000, 6'h01, 1'b0);

        // LDA: full ring walk from reset.
        fetch("lda", 4'h0);
        step("lda_t4", 1'b0, 1'b1, 4'h0, 12'h240, 6'h08, 1'b0);
        step("lda_t5", 1'b0, 1'b1, 4'h0, 12'h120, 6'h10, 1'b0);
        step("lda_t6", 1'b0, 1'b1, 4'h0, 12'h000, 6'h20, 1'b0);

        // ADD, with opcode changed to OUT ahead of the T6 edge.
        fetch("add", 4'h1);
        step("add_t4", 1'b0, 1'b1, 4'h1, 12'h240, 6'h08, 1'b0);
        step("add_t5", 1'b0, 1'b1, 4'h1, 12'h102, 6'h10, 1'b0);
        step("add_t6", 1'b0, 1'b1, 4'hE, 12'h024, 6'h20, 1'b0);

        fetch("sub", 4'h2);
        step("sub_t4", 1'b0, 1'b1, 4'h2, 12'h240, 6'h08, 1'b0);
        step("sub_t5", 1'b0, 1'b1, 4'h2, 12'h102, 6'h10, 1'b0);
        step("sub_t6", 1'b0, 1'b1, 4'h2, 12'h02C, 6'h20, 1'b0);

        fetch("out", 4'hE);
        step("out_t4", 1'b0, 1'b1, 4'hE, 12'h011, 6'h08, 1'b0);
        step("out_t5", 1'b0, 1'b1, 4'hE, 12'h000, 6'h10, 1'b0);
        step("out_t6", 1'b0, 1'b1, 4'hE, 12'h000, 6'h20, 1'b0);

        fetch("undef", 4'h5);
        step("undef_t4", 1'b0, 1'b1, 4'h5, 12'h000, 6'h08, 1'b0);
        step("undef_t5", 1'b0, 1'b1, 4'h5, 12'h000, 6'h10, 1'b0);
        step("undef_t6", 1'b0, 1'b1, 4'h5, 12'h000, 6'h20, 1'b0);

        // Freeze in T2 for five cycles; T2 is re-presented once, then T3.
        step("frz_t1", 1'b0, 1'b1, 4'h0, 12'h600, 6'h01, 1'b0);
        step("frz_t2", 1'b0, 1'b1, 4'h0, 12'h800, 6'h02, 1'b0);
        for (int i = 0; i < 5; i++)
            step("frz_hold", 1'b0, 1'b0, 4'h0, 12'h000, 6'h02, 1'b0);
        step("frz_resume", 1'b0, 1'b1, 4'h0, 12'h800, 6'h02, 1'b0);
        step("frz_t3", 1'b0, 1'b1, 4'h0, 12'h180, 6'h04, 1'b0);
        step("frz_t4", 1'b0, 1'b1, 4'h0, 12'h240, 6'h08, 1'b0);
        step("frz_t5", 1'b0, 1'b1, 4'h0, 12'h120, 6'h10, 1'b0);
        step("frz_t6", 1'b0, 1'b1, 4'h0, 12'h000, 6'h20, 1'b0);

        // Reset in T5 of an ADD aborts the instruction.
        fetch("abort", 4'h1);
        step("abort_t4", 1'b0, 1'b1, 4'h1, 12'h240, 6'h08, 1'b0);
        step("abort_t5", 1'b0, 1'b1, 4'h1, 12'h102, 6'h10, 1'b0);
        step("abort_rst", 1'b1, 1'b1, 4'h1, 12'h000, 6'h01, 1'b0);
        step("abort_t1", 1'b0, 1'b1, 4'h1, 12'h600, 6'h01, 1'b0);
        step("abort_t2", 1'b0, 1'b1, 4'h1, 12'h800, 6'h02, 1'b0);
        step("abort_t3", 1'b0, 1'b1, 4'h1, 12'h180, 6'h04, 1'b0);

        // Freeze on the T3->T4 edge: HLT on the bus while frozen is never captured.
        step("defer_hold", 1'b0, 1'b0, 4'hF, 12'h000, 6'h04, 1'b0);
        step("defer_t3", 1'b0, 1'b1, 4'h1, 12'h180, 6'h04, 1'b0);
        step("defer_t4", 1'b0, 1'b1, 4'h1, 12'h240, 6'h08, 1'b0);
        step("defer_t5", 1'b0, 1'b1, 4'h1, 12'h102, 6'h10, 1'b0);
        step("defer_t6", 1'b0, 1'b1, 4'h1, 12'h024, 6'h20, 1'b0);

        // HLT: sticky at T4 with run toggling, released only by reset.
        fetch("hlt", 4'hF);
        step("hlt_t4", 1'b0, 1'b1, 4'hF, 12'h000, 6'h08, 1'b1);
        for (int i = 0; i < 22; i++)
            step("hlt_hold", 1'b0, i[0], 4'(i), 12'h000, 6'h08, 1'b1);
        step("hlt_rst", 1'b1, 1'b0, 4'h0, 12'h000, 6'h01, 1'b0);
        step("hlt_t1", 1'b0, 1'b1, 4'h0, 12'h600, 6'h01, 1'b0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clock);
        #2;
        check("scoreboard_drain", 12'(sb.size()), 12'h000);

        // Randomised opcode/run/reset stream; the monitor checks bus exclusivity every cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            #1;
            reset         = ($urandom_range(0, 39) == 0);
            bus_if.run    = ($urandom_range(0, 3) != 0);
            bus_if.opcode = ($urandom_range(0, 19) == 0) ? 4'hF : ops[$urandom_range(0, 4)];
        end

        @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
